// File: rtl/gcd_arbiter.sv
// Purpose: shares one GCD engine among N requesters, round-robin, one op in flight.
// Latency: accept -> gcd_in_valid 1 cycle; gcd_out_valid -> resp_valid 1 cycle.
// Backpressure: req_ready only in IDLE; operand held on the engine until gcd_in_ready.
//
// Ports:
//   clk, reset                  clock and synchronous active-high reset
//   req_valid/req_ready/req_data  per-requester operand handshake (32-bit slices)
//   resp_valid/resp_data/resp_err one-hot result pulse, result, timeout flag
//   gcd_in_*/gcd_out_*          shared engine operand/result interface
//   gcd_reset                   engine reset = reset OR watchdog flush
module gcd_arbiter #(
    parameter int N       = 4,
    parameter int IDW     = $clog2(N),
    parameter int TIMEOUT = 1024
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req_valid,
    input  logic [N*32-1:0] req_data,
    output logic [N-1:0]    req_ready,
    output logic [N-1:0]    resp_valid,
    output logic [15:0]     resp_data,
    output logic            resp_err,
    output logic            gcd_in_valid,
    output logic [31:0]     gcd_in_data,
    input  logic            gcd_in_ready,
    input  logic            gcd_out_valid,
    input  logic [15:0]     gcd_out_data,
    output logic            gcd_reset
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FLUSH} state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]  tag_q, tag_d;
    logic [31:0]     op_q, op_d;
    logic [15:0]     wdog_q, wdog_d;
    logic [N-1:0]    resp_valid_q, resp_valid_d;
    logic [15:0]     resp_data_q, resp_data_d;
    logic            resp_err_q, resp_err_d;
    logic            gcd_in_valid_q, gcd_in_valid_d;
    logic            flush_q, flush_d;

    logic [31:0]     req_words [N];
    logic            grant_vld;
    logic [IDW-1:0]  grant_idx;
    logic [IDW-1:0]  cand;

    genvar gi;
    for (gi = 0; gi < N; gi++) begin : g_unpack
        assign req_words[gi] = req_data[32*gi +: 32];
    end

    // Round-robin search: first valid requester at or after rr_ptr, wrapping mod N.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < N; k++) begin
            cand = IDW'((int'(rr_ptr_q) + k) % N);
            if (!grant_vld && req_valid[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == S_IDLE && grant_vld) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        tag_d          = tag_q;
        op_d           = op_q;
        wdog_d         = wdog_q;
        resp_valid_d   = '0;
        resp_data_d    = resp_data_q;
        resp_err_d     = resp_err_q;
        gcd_in_valid_d = gcd_in_valid_q;
        flush_d        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (grant_vld) begin
                    op_d           = req_words[grant_idx];
                    tag_d          = grant_idx;
                    rr_ptr_d       = (grant_idx == IDW'(N-1)) ? '0 : grant_idx + IDW'(1);
                    gcd_in_valid_d = 1'b1;
                    state_d        = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (gcd_in_ready) begin
                    gcd_in_valid_d = 1'b0;
                    wdog_d         = '0;
                    state_d        = S_WAIT;
                end
            end
            S_WAIT: begin
                wdog_d = wdog_q + 16'd1;
                // A result arriving on the timeout cycle still wins: no flush.
                if (gcd_out_valid) begin
                    resp_valid_d[tag_q] = 1'b1;
                    resp_data_d         = gcd_out_data;
                    resp_err_d          = 1'b0;
                    state_d             = S_IDLE;
                end else if (wdog_q == 16'(TIMEOUT-1)) begin
                    resp_valid_d[tag_q] = 1'b1;
                    resp_data_d         = '0;
                    resp_err_d          = 1'b1;
                    flush_d             = 1'b1;
                    state_d             = S_FLUSH;
                end
            end
            S_FLUSH: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            rr_ptr_q       <= '0;
            tag_q          <= '0;
            op_q           <= '0;
            wdog_q         <= '0;
            resp_valid_q   <= '0;
            resp_data_q    <= '0;
            resp_err_q     <= 1'b0;
            gcd_in_valid_q <= 1'b0;
            flush_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            tag_q          <= tag_d;
            op_q           <= op_d;
            wdog_q         <= wdog_d;
            resp_valid_q   <= resp_valid_d;
            resp_data_q    <= resp_data_d;
            resp_err_q     <= resp_err_d;
            gcd_in_valid_q <= gcd_in_valid_d;
            flush_q        <= flush_d;
        end
    end

    assign resp_valid   = resp_valid_q;
    assign resp_data    = resp_data_q;
    assign resp_err     = resp_err_q;
    assign gcd_in_valid = gcd_in_valid_q;
    assign gcd_in_data  = op_q;
    // Combinational so the engine is held in reset for the whole system reset too.
    assign gcd_reset    = reset | flush_q;

endmodule

// File: tb/tb_gcd_arbiter.sv
module tb_gcd_arbiter;
    localparam int N  = 4;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N*32-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    resp_valid;
    logic [15:0]     resp_data;
    logic            resp_err;
    logic            gcd_in_valid;
    logic [31:0]     gcd_in_data;
    logic            gcd_in_ready;
    logic            gcd_out_valid = 1'b0;
    logic [15:0]     gcd_out_data  = 16'd0;
    logic            gcd_reset;

    always #5 clk = ~clk;

    gcd_arbiter #(.N(N), .IDW(2), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
        .gcd_in_valid(gcd_in_valid), .gcd_in_data(gcd_in_data), .gcd_in_ready(gcd_in_ready),
        .gcd_out_valid(gcd_out_valid), .gcd_out_data(gcd_out_data), .gcd_reset(gcd_reset)
    );

    int tot = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tot++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    // Engine model: 4-cycle Euclid after accept; never finishes when lo==0, hi!=0.
    logic        rdy_en;
    logic        eng_busy = 1'b0;
    logic [15:0] ea = 16'd0, eb = 16'd0;
    int          ecnt = 0;
    assign gcd_in_ready = rdy_en & ~eng_busy;

    function automatic logic [15:0] gcd16(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] x, y, t;
        x = a; y = b;
        while (y != 0) begin
            t = x % y; x = y; y = t;
        end
        return x;
    endfunction

    always @(posedge clk) begin
        if (gcd_reset) begin
            eng_busy      <= 1'b0;
            gcd_out_valid <= 1'b0;
            ecnt          <= 0;
        end else begin
            gcd_out_valid <= 1'b0;
            if (!eng_busy) begin
                if (gcd_in_valid && gcd_in_ready) begin
                    eng_busy <= 1'b1;
                    ea       <= gcd_in_data[31:16];
                    eb       <= gcd_in_data[15:0];
                    ecnt     <= 3;
                end
            end else if (!(eb == 0 && ea != 0)) begin
                if (ecnt == 0) begin
                    gcd_out_valid <= 1'b1;
                    gcd_out_data  <= gcd16(ea, eb);
                    eng_busy      <= 1'b0;
                end else begin
                    ecnt <= ecnt - 1;
                end
            end
        end
    end

    // Logs of accepts and responses, sampled mid-cycle.
    int          gnt_q[$];
    logic [N-1:0] rv_q[$];
    logic [15:0] rd_q[$];
    logic        re_q[$];

    always @(negedge clk) begin
        if (!reset) begin
            for (int i = 0; i < N; i++)
                if (req_valid[i] && req_ready[i]) gnt_q.push_back(i);
            if (resp_valid != 0) begin
                rv_q.push_back(resp_valid);
                rd_q.push_back(resp_data);
                re_q.push_back(resp_err);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // Hold each requester until accepted; return once nr new responses arrived.
    task automatic serve(input int nr, input string tag);
        int r0, cyc;
        logic [N-1:0] m;
        r0 = rv_q.size();
        cyc = 0;
        while ((req_valid != 0 || rv_q.size() < r0 + nr) && cyc < 400) begin
            @(negedge clk);
            m = req_valid & req_ready;
            @(posedge clk);
            #1;
            req_valid = req_valid & ~m;
            cyc++;
        end
        chk({tag, "_done"}, 32'(cyc < 400), 32'd1);
    endtask

    task automatic chk_rsp(input string tag, input int k, input logic [31:0] v,
                           input logic [31:0] d, input logic [31:0] e);
        if (k < rv_q.size()) begin
            chk({tag, "_vld"}, 32'(rv_q[k]), v);
            chk({tag, "_dat"}, 32'(rd_q[k]), d);
            chk({tag, "_err"}, 32'(re_q[k]), e);
        end else begin
            chk({tag, "_missing"}, 32'(rv_q.size()), 32'(k + 1));
        end
    endtask

    task automatic chk_gnt(input string tag, input int k, input int g);
        if (k < gnt_q.size()) chk(tag, 32'(gnt_q[k]), 32'(g));
        else chk({tag, "_missing"}, 32'(gnt_q.size()), 32'(k + 1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got 0 want 1");
        $fatal(1);
    end

    initial begin
        int g0, r0, cyc;
        int exp2 [4] = '{4, 5, 7, 3};
        reset = 1'b1; req_valid = '0; req_data = '0; rdy_en = 1'b1;
        step();
        chk("rst_gcd_reset", 32'(gcd_reset), 32'd1);
        step(); step();
        reset = 1'b0;
        #1;
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_data", 32'(resp_data), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_in_valid", 32'(gcd_in_valid), 32'd0);
        chk("rst_gcd_reset_low", 32'(gcd_reset), 32'd0);

        // Single request: gcd(48,18)=6
        req_data[31:0] = 32'h0030_0012;
        req_valid = 4'b0001;
        #1;
        chk("t1_rdy", 32'(req_ready), 32'h1);
        step();
        req_valid = '0;
        chk("t1_in_valid", 32'(gcd_in_valid), 32'd1);
        chk("t1_in_data", gcd_in_data, 32'h0030_0012);
        chk("t1_rdy_issue", 32'(req_ready), 32'h0);
        cyc = 0;
        while (resp_valid == 0 && cyc < 50) begin step(); cyc++; end
        chk("t1_rv", 32'(resp_valid), 32'h1);
        chk("t1_rd", 32'(resp_data), 32'd6);
        chk("t1_re", 32'(resp_err), 32'd0);
        chk("t1_no_flush", 32'(gcd_reset), 32'd0);
        step();
        chk("t1_pulse", 32'(resp_valid), 32'h0);
        chk("t1_hold", 32'(resp_data), 32'd6);

        // All four from reset: order 0,1,2,3; then 0 and 2: order 0,2
        do_reset();
        g0 = gnt_q.size(); r0 = rv_q.size();
        req_data = {32'h0009_0006, 32'h0015_000E, 32'h000F_0019, 32'h000C_0008};
        req_valid = 4'b1111;
        serve(4, "t2a");
        for (int k = 0; k < 4; k++) begin
            chk_gnt($sformatf("t2a_gnt%0d", k), g0 + k, k);
            chk_rsp($sformatf("t2a_rsp%0d", k), r0 + k, 32'(1 << k), 32'(exp2[k]), 32'd0);
        end
        g0 = gnt_q.size(); r0 = rv_q.size();
        req_data[31:0]  = 32'h0064_004B;
        req_data[95:64] = 32'h0024_003C;
        req_valid = 4'b0101;
        serve(2, "t2b");
        chk_gnt("t2b_gnt0", g0, 0);
        chk_gnt("t2b_gnt1", g0 + 1, 2);
        chk_rsp("t2b_rsp0", r0, 32'h1, 32'd25, 32'd0);
        chk_rsp("t2b_rsp1", r0 + 1, 32'h4, 32'd12, 32'd0);

        // Watchdog: hanging operand on requester 1
        req_data[63:32] = 32'h0005_0000;
        req_valid = 4'b0010;
        #1;
        chk("t3_rdy", 32'(req_ready), 32'h2);
        step();
        req_valid = '0;
        cyc = 0;
        while (resp_valid == 0 && cyc < 100) begin step(); cyc++; end
        chk("t3_wait_cycles", 32'(cyc), 32'(TO + 1));
        chk("t3_rv", 32'(resp_valid), 32'h2);
        chk("t3_rd", 32'(resp_data), 32'd0);
        chk("t3_re", 32'(resp_err), 32'd1);
        chk("t3_flush", 32'(gcd_reset), 32'd1);
        step();
        chk("t3_flush_end", 32'(gcd_reset), 32'd0);
        chk("t3_pulse", 32'(resp_valid), 32'h0);
        chk("t3_err_hold", 32'(resp_err), 32'd1);
        g0 = gnt_q.size(); r0 = rv_q.size();
        req_data[63:32] = 32'h0007_000E;
        req_valid = 4'b0010;
        serve(1, "t3b");
        chk_gnt("t3b_gnt", g0, 1);
        chk_rsp("t3b_rsp", r0, 32'h2, 32'd7, 32'd0);

        // Engine stall: operand held, no other grants
        rdy_en = 1'b0;
        g0 = gnt_q.size(); r0 = rv_q.size();
        req_data[95:64] = 32'h001B_0012;
        req_data[31:0]  = 32'h0008_000C;
        req_valid = 4'b0101;
        #1;
        chk("t4_rdy", 32'(req_ready), 32'h4);
        step();
        req_valid = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("t4_in_valid%0d", k), 32'(gcd_in_valid), 32'd1);
            chk($sformatf("t4_in_data%0d", k), gcd_in_data, 32'h001B_0012);
            chk($sformatf("t4_rdy%0d", k), 32'(req_ready), 32'h0);
            step();
        end
        rdy_en = 1'b1;
        step();
        chk("t4_xfer", 32'(gcd_in_valid), 32'd0);
        chk("t4_rdy_wait", 32'(req_ready), 32'h0);
        serve(2, "t4");
        chk_gnt("t4_gnt0", g0, 2);
        chk_gnt("t4_gnt1", g0 + 1, 0);
        chk_rsp("t4_rsp0", r0, 32'h4, 32'd9, 32'd0);
        chk_rsp("t4_rsp1", r0 + 1, 32'h1, 32'd4, 32'd0);

        // High half zero: gcd(0,9)=9
        g0 = gnt_q.size(); r0 = rv_q.size();
        req_data[127:96] = 32'h0000_0009;
        req_valid = 4'b1000;
        serve(1, "t5");
        chk_gnt("t5_gnt", g0, 3);
        chk_rsp("t5_rsp", r0, 32'h8, 32'd9, 32'd0);

        // Reset while in WAIT: op discarded, search restarts at index 0
        req_data[63:32] = 32'h0005_0000;
        req_valid = 4'b0010;
        #1;
        chk("t6_rdy", 32'(req_ready), 32'h2);
        step();
        req_valid = '0;
        step(); step(); step();
        r0 = rv_q.size();
        reset = 1'b1;
        #1;
        chk("t6_gcd_reset", 32'(gcd_reset), 32'd1);
        step();
        reset = 1'b0;
        for (int k = 0; k < 30; k++) step();
        chk("t6_no_resp", 32'(rv_q.size()), 32'(r0));
        chk("t6_idle", 32'(gcd_in_valid), 32'd0);
        g0 = gnt_q.size(); r0 = rv_q.size();
        req_data[63:32]  = 32'h0030_0012;
        req_data[127:96] = 32'h0000_0009;
        req_valid = 4'b1010;
        #1;
        chk("t6_rr0", 32'(req_ready), 32'h2);
        serve(2, "t6");
        chk_gnt("t6_gnt0", g0, 1);
        chk_gnt("t6_gnt1", g0 + 1, 3);
        chk_rsp("t6_rsp0", r0, 32'h2, 32'd6, 32'd0);
        chk_rsp("t6_rsp1", r0 + 1, 32'h8, 32'd9, 32'd0);

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end
endmodule
